// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the three buses around the data-memory arbiter:
//   CPU_*  : CPU MEM-stage requester (request, command, response, stall)
//   DBG_*  : debug/readback requester (request, command, response)
//   MEM_*  : single-ported data memory (strobes, address, write/read data)
// Modports:
//   slave  : the arbiter (takes requests and memory read data, drives the rest)
//   master : the surroundings (requesters plus the memory model)
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              CPU_REQ;
  logic              CPU_WE;
  logic [31:0]       CPU_ADDR;
  logic [DATA_W-1:0] CPU_WDATA;
  logic              CPU_ACK;
  logic              CPU_ERR;
  logic [DATA_W-1:0] CPU_RDATA;
  logic              CPU_STALL;

  logic              DBG_REQ;
  logic              DBG_WE;
  logic [31:0]       DBG_ADDR;
  logic [DATA_W-1:0] DBG_WDATA;
  logic              DBG_ACK;
  logic              DBG_ERR;
  logic [DATA_W-1:0] DBG_RDATA;

  logic              MEM_ENABLE;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [31:0]       MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output CPU_ACK, CPU_ERR, CPU_RDATA, CPU_STALL,
    input  DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA,
    output DBG_ACK, DBG_ERR, DBG_RDATA,
    output MEM_ENABLE, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA
  );

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  CPU_ACK, CPU_ERR, CPU_RDATA, CPU_STALL,
    output DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA,
    input  DBG_ACK, DBG_ERR, DBG_RDATA,
    input  MEM_ENABLE, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-ported data memory between the CPU MEM stage and the
// debug unit. CPU has priority; a starvation counter forces a debug grant
// after STARVE_LIMIT consecutive CPU grants made while debug was waiting.
// Each transaction runs IDLE -> ACCESS -> DONE; the owner gets a one-cycle
// ACK in DONE with registered read data and an out-of-range error flag.
// Ports:
//   CLK    : clock, all state changes on posedge
//   RESET  : asynchronous, active-high reset
//   bus    : dmem_arbiter_if.slave (CPU_*, DBG_*, MEM_* signal groups)
module dmem_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_next;
  logic              owner_dbg;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        starve_cnt;
  logic              err_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              grant_cpu, grant_dbg;
  logic              in_range;
  logic [DATA_W-1:0] capture_data;

  // Debug wins when alone, or when it has waited through STARVE_LIMIT CPU grants.
  always_comb begin
    grant_dbg = bus.DBG_REQ && (!bus.CPU_REQ || (starve_cnt == LIMIT));
    grant_cpu = bus.CPU_REQ && !grant_dbg;
  end

  // Upper address bits must be zero; an out-of-range access never reaches memory.
  assign in_range     = (lat_addr[31:ADDR_W] == '0);
  assign capture_data = (!lat_we && in_range) ? bus.MEM_RDATA : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Strobes and ACKs decode from the state alone, so an asynchronous reset
  // drops them in the same instant and cuts a pending memory write.
  always_comb begin
    state_next     = state;
    bus.MEM_ENABLE = 1'b0;
    bus.MEM_READ   = 1'b0;
    bus.MEM_WRITE  = 1'b0;
    bus.MEM_ADDR   = '0;
    bus.MEM_WDATA  = '0;
    bus.CPU_ACK    = 1'b0;
    bus.CPU_ERR    = 1'b0;
    bus.DBG_ACK    = 1'b0;
    bus.DBG_ERR    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_cpu || grant_dbg) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = DONE;
        if (in_range) begin
          bus.MEM_ENABLE = 1'b1;
          bus.MEM_READ   = !lat_we;
          bus.MEM_WRITE  = lat_we;
          bus.MEM_ADDR   = {{(32-ADDR_W){1'b0}}, lat_addr[ADDR_W-1:0]};
          bus.MEM_WDATA  = lat_we ? lat_wdata : '0;
        end
      end
      DONE: begin
        state_next  = IDLE;
        bus.CPU_ACK = !owner_dbg;
        bus.CPU_ERR = !owner_dbg && err_q;
        bus.DBG_ACK = owner_dbg;
        bus.DBG_ERR = owner_dbg && err_q;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch on grant, response capture at the edge that ends ACCESS.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_dbg   <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (state == IDLE && (grant_cpu || grant_dbg)) begin
        owner_dbg <= grant_dbg;
        lat_we    <= grant_dbg ? bus.DBG_WE    : bus.CPU_WE;
        lat_addr  <= grant_dbg ? bus.DBG_ADDR  : bus.CPU_ADDR;
        lat_wdata <= grant_dbg ? bus.DBG_WDATA : bus.CPU_WDATA;
      end
      if (state == ACCESS) begin
        err_q <= !in_range;
        if (owner_dbg) dbg_rdata_q <= capture_data;
        else           cpu_rdata_q <= capture_data;
      end
    end
  end

  // Starvation counter only moves in IDLE; a CPU grant without debug waiting
  // also falls into the clear branch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_dbg) begin
        starve_cnt <= '0;
      end else if (grant_cpu && bus.DBG_REQ) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else if (!bus.DBG_REQ) begin
        starve_cnt <= '0;
      end
    end
  end

  assign bus.CPU_RDATA = cpu_rdata_q;
  assign bus.DBG_RDATA = dbg_rdata_q;
  assign bus.CPU_STALL = bus.CPU_REQ & ~bus.CPU_ACK;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. Stimulus pushes the expected
// response of each transaction into a scoreboard queue; a negedge monitor
// pops and compares whenever CPU_ACK or DBG_ACK is presented. A 32-word
// memory model writes at negedge and reads combinationally.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(32)) bus();

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus.slave)
  );

  logic [31:0] mem [0:31] = '{default: 32'd0};
  assign bus.MEM_RDATA = mem[bus.MEM_ADDR[4:0]];
  always @(negedge clk) begin
    if (bus.MEM_ENABLE && bus.MEM_WRITE) mem[bus.MEM_ADDR[4:0]] <= bus.MEM_WDATA;
  end

  typedef struct packed {
    logic        is_dbg;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   dbg_ack_times[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cycle = 0;
  int   ack_total = 0;
  int   last_write_cycle = -1;
  logic mem_en_seen = 1'b0;

  always @(posedge clk) cycle++;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: response checking and memory-strobe spacing.
  always @(negedge clk) begin
    exp_t e;
    if (bus.MEM_ENABLE) mem_en_seen = 1'b1;
    if (bus.MEM_WRITE) begin
      if (last_write_cycle >= 0) check_output("mem_write_gap_ge3", 32'(cycle - last_write_cycle >= 3), 32'd1);
      last_write_cycle = cycle;
    end
    if (bus.CPU_ACK && bus.DBG_ACK) check_output("dual_ack", 32'd1, 32'd0);
    if (bus.CPU_ACK || bus.DBG_ACK) begin
      ack_total++;
      if (bus.DBG_ACK) dbg_ack_times.push_back(cycle);
      if (exp_q.size() == 0) begin
        check_output("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("ack_owner_dbg", {31'd0, bus.DBG_ACK}, {31'd0, e.is_dbg});
        if (e.is_dbg) begin
          check_output("dbg_err", {31'd0, bus.DBG_ERR}, {31'd0, e.err});
          check_output("dbg_rdata", bus.DBG_RDATA, e.rdata);
        end else begin
          check_output("cpu_err", {31'd0, bus.CPU_ERR}, {31'd0, e.err});
          check_output("cpu_rdata", bus.CPU_RDATA, e.rdata);
          check_output("cpu_stall_at_ack", {31'd0, bus.CPU_STALL}, 32'd0);
        end
      end
    end
  end

  task automatic push_exp(input logic is_dbg, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.is_dbg = is_dbg;
    e.err    = err;
    e.rdata  = rdata;
    exp_q.push_back(e);
  endtask

  // Waits on negedges until the monitor has counted 'target' ACKs.
  task automatic wait_acks(input int target, input int budget, output int waited, output int stall_cnt);
    waited = 0;
    stall_cnt = 0;
    while (ack_total < target && waited < budget) begin
      @(negedge clk);
      #1;
      waited++;
      if (bus.CPU_STALL) stall_cnt++;
    end
    if (ack_total < target) check_output("ack_timeout", 32'(ack_total), 32'(target));
  endtask

  // One complete transaction on one port; called at posedge+1, returns at posedge+1.
  task automatic apply_stimulus(input logic is_dbg, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                                output int latency, output int stall_cnt);
    int target;
    target = ack_total + 1;
    push_exp(is_dbg, err, rdata);
    if (is_dbg) begin
      bus.DBG_REQ = 1'b1; bus.DBG_WE = we; bus.DBG_ADDR = addr; bus.DBG_WDATA = wdata;
    end else begin
      bus.CPU_REQ = 1'b1; bus.CPU_WE = we; bus.CPU_ADDR = addr; bus.CPU_WDATA = wdata;
    end
    wait_acks(target, 20, latency, stall_cnt);
    @(posedge clk);
    #1;
    bus.CPU_REQ = 1'b0;
    bus.DBG_REQ = 1'b0;
  endtask

  initial begin
    int lat, st, acks_before, target;
    bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADDR = '0; bus.CPU_WDATA = '0;
    bus.DBG_REQ = 1'b0; bus.DBG_WE = 1'b0; bus.DBG_ADDR = '0; bus.DBG_WDATA = '0;

    // Reset values; stall follows CPU_REQ while in reset.
    repeat (2) @(posedge clk);
    #1;
    bus.CPU_REQ = 1'b1;
    #1;
    check_output("rst_cpu_stall_hi", {31'd0, bus.CPU_STALL}, 32'd1);
    check_output("rst_cpu_ack", {31'd0, bus.CPU_ACK}, 32'd0);
    check_output("rst_dbg_ack", {31'd0, bus.DBG_ACK}, 32'd0);
    check_output("rst_mem_enable", {31'd0, bus.MEM_ENABLE}, 32'd0);
    check_output("rst_cpu_rdata", bus.CPU_RDATA, 32'd0);
    check_output("rst_dbg_rdata", bus.DBG_RDATA, 32'd0);
    bus.CPU_REQ = 1'b0;
    #1;
    check_output("rst_cpu_stall_lo", {31'd0, bus.CPU_STALL}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Put known data in word 3, read it back so CPU_RDATA is non-zero.
    apply_stimulus(1'b0, 1'b1, 32'd3, 32'h1111_1111, 1'b0, 32'd0, lat, st);
    apply_stimulus(1'b0, 1'b0, 32'd3, 32'd0, 1'b0, 32'h1111_1111, lat, st);

    // Reset mid-ACCESS of a CPU write to word 3, before the access negedge.
    acks_before = ack_total;
    bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 32'd3; bus.CPU_WDATA = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    check_output("abort_write_strobe", {31'd0, bus.MEM_WRITE}, 32'd1);
    reset = 1'b1;
    bus.CPU_REQ = 1'b0;
    #1;
    check_output("abort_mem_write", {31'd0, bus.MEM_WRITE}, 32'd0);
    check_output("abort_mem_enable", {31'd0, bus.MEM_ENABLE}, 32'd0);
    check_output("abort_mem_addr", bus.MEM_ADDR, 32'd0);
    check_output("abort_cpu_rdata", bus.CPU_RDATA, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("abort_mem3_kept", mem[3], 32'h1111_1111);
    check_output("abort_no_ack", 32'(ack_total), 32'(acks_before));
    reset = 1'b0;
    @(posedge clk); #1;

    // CPU write then read of word 7, with latency and stall length.
    apply_stimulus(1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF, 1'b0, 32'd0, lat, st);
    check_output("wr_latency", 32'(lat), 32'd3);
    check_output("wr_stall_cycles", 32'(st), 32'd2);
    apply_stimulus(1'b0, 1'b0, 32'd7, 32'd0, 1'b0, 32'hDEAD_BEEF, lat, st);
    check_output("rd_latency", 32'(lat), 32'd3);
    check_output("rd_stall_cycles", 32'(st), 32'd2);

    // Debug reads: in range first, then out of range (clears RDATA, no memory touch).
    apply_stimulus(1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 32'hDEAD_BEEF, lat, st);
    mem_en_seen = 1'b0;
    apply_stimulus(1'b1, 1'b0, 32'h20, 32'd0, 1'b1, 32'd0, lat, st);
    check_output("oor_rd_mem_enable", {31'd0, mem_en_seen}, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h27, 32'h5555_5555, 1'b1, 32'd0, lat, st);
    check_output("oor_wr_mem_enable", {31'd0, mem_en_seen}, 32'd0);
    check_output("oor_wr_mem7_kept", mem[7], 32'hDEAD_BEEF);
    apply_stimulus(1'b0, 1'b0, 32'h8000_0001, 32'd0, 1'b1, 32'd0, lat, st);

    // Priority with both requesting continuously: 4 CPU, 1 DBG, repeated.
    apply_stimulus(1'b0, 1'b1, 32'd1, 32'h0000_0100, 1'b0, 32'd0, lat, st);
    apply_stimulus(1'b1, 1'b1, 32'd2, 32'h0000_0200, 1'b0, 32'd0, lat, st);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 32'h0000_0100);
      push_exp(1'b1, 1'b0, 32'h0000_0200);
    end
    dbg_ack_times.delete();
    target = ack_total + 10;
    bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADDR = 32'd1;
    bus.DBG_REQ = 1'b1; bus.DBG_WE = 1'b0; bus.DBG_ADDR = 32'd2;
    wait_acks(target, 60, lat, st);
    @(posedge clk); #1;
    bus.CPU_REQ = 1'b0; bus.DBG_REQ = 1'b0;
    check_output("prio_dbg_ack_count", 32'(dbg_ack_times.size()), 32'd2);
    if (dbg_ack_times.size() == 2)
      check_output("prio_dbg_ack_spacing", 32'(dbg_ack_times[1] - dbg_ack_times[0]), 32'd15);

    // Back-to-back CPU writes with REQ held across ACK.
    push_exp(1'b0, 1'b0, 32'd0);
    push_exp(1'b0, 1'b0, 32'd0);
    target = ack_total + 2;
    bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 32'd9; bus.CPU_WDATA = 32'h0000_0099;
    wait_acks(target, 20, lat, st);
    @(posedge clk); #1;
    bus.CPU_REQ = 1'b0;
    check_output("b2b_cycles", 32'(lat), 32'd6);
    check_output("b2b_mem9", mem[9], 32'h0000_0099);

    // Debug withdraws after 3 CPU grants; the counter restarts from zero.
    for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b0, 32'h0000_0100);
    target = ack_total + 3;
    bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADDR = 32'd1;
    bus.DBG_REQ = 1'b1; bus.DBG_WE = 1'b0; bus.DBG_ADDR = 32'd2;
    wait_acks(target, 30, lat, st);
    @(posedge clk); #1;
    bus.DBG_REQ = 1'b0;
    push_exp(1'b0, 1'b0, 32'h0000_0100);
    target = ack_total + 1;
    wait_acks(target, 10, lat, st);
    @(posedge clk); #1;
    bus.DBG_REQ = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 32'h0000_0100);
    push_exp(1'b1, 1'b0, 32'h0000_0200);
    target = ack_total + 5;
    wait_acks(target, 30, lat, st);
    @(posedge clk); #1;
    bus.CPU_REQ = 1'b0; bus.DBG_REQ = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported 32-word data memory. It shares the memory between the CPU MEM stage and the debug/readback unit, with CPU priority and a starvation guard for debug. It runs one access per transaction through a fixed IDLE→ACCESS→DONE sequence, returns registered read data with a one-cycle ACK pulse, and rejects out-of-range addresses without touching memory.

## Interface
- ADDR_W, 5, memory word-address width; valid addresses are 0..2^ADDR_W-1
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive CPU grants with DBG_REQ pending before DBG is forced; range 1..15

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  reset RESET, asynchronous, active-high
- CPU_REQ  in  1  CPU access request; held with command until CPU_ACK
- CPU_WE  in  1  1 = write, 0 = read
- CPU_ADDR  in  32  word address
- CPU_WDATA  in  DATA_W  write data
- CPU_ACK  out  1  one-cycle completion pulse
- CPU_ERR  out  1  valid with CPU_ACK; address out of range
- CPU_RDATA  out  DATA_W  read data, valid with CPU_ACK
- CPU_STALL  out  1  combinational: CPU_REQ & ~CPU_ACK
- DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA  in  same widths as CPU_*  debug requester
- DBG_ACK, DBG_ERR, DBG_RDATA  out  same as CPU_*  debug response
- MEM_ENABLE  out  1  memory enable
- MEM_READ  out  1  memory read strobe
- MEM_WRITE  out  1  memory write strobe
- MEM_ADDR  out  32  memory address, zero-extended from ADDR_W bits
- MEM_WDATA  out  DATA_W  memory write data
- MEM_RDATA  in  DATA_W  memory combinational read data

## Operation
- FSM states and transitions:
  - IDLE: if any REQ, pick owner, latch owner, WE, ADDR and WDATA, then go to ACCESS. Otherwise stay.
  - ACCESS: lasts exactly 1 cycle, then go to DONE.
  - DONE: lasts exactly 1 cycle, then go to IDLE.
- Arbitration in IDLE:
  - Only CPU_REQ high: CPU wins. Only DBG_REQ high: DBG wins.
  - Both high: CPU wins unless starve_cnt == STARVE_LIMIT, in which case DBG wins.
- starve_cnt, 4 bits:
  - Increments on each CPU grant made while DBG_REQ = 1.
  - Clears on any DBG grant.
  - Clears in any IDLE cycle where DBG_REQ = 0.
  - Saturates at STARVE_LIMIT.
- Range check: the latched address is out of range if bits [31:ADDR_W] ≠ 0.
- Memory drive during ACCESS, valid address:
  - MEM_ENABLE = 1, MEM_ADDR = latched address.
  - Write: MEM_WRITE = 1, MEM_WDATA = latched WDATA.
  - Read: MEM_READ = 1.
- Memory drive during ACCESS, out-of-range address: all MEM_* = 0 and no memory side effect.
- Memory drive outside ACCESS: all MEM_* = 0.
- Response capture at the posedge ending ACCESS:
  - Owner's RDATA register ← MEM_RDATA on a valid read.
  - Owner's RDATA register ← 0 on a write or an out-of-range access.
  - ERR register ← out-of-range flag.
- DONE: the owner's ACK = 1 and ERR is valid. The non-owner's ACK stays 0.
- RDATA holds its value until that port's next completion.
- A requester must deassert REQ, or present a new command, in the cycle after ACK. DONE never arbitrates, so the same REQ held high is re-granted only from the following IDLE.

## Timing
- Reset values (asynchronous):
  - State IDLE, starve_cnt 0.
  - All ACK, ERR and MEM_* outputs 0.
  - CPU_RDATA and DBG_RDATA 0.
  - CPU_STALL follows CPU_REQ.
- Latency: REQ sampled high at edge N (the edge that leaves IDLE) → ACCESS during cycle N..N+1 → ACK high during cycle N+1..N+2.
- Throughput: at best one transaction per 3 cycles, i.e. IDLE→ACCESS→DONE→IDLE.
- The memory writes at the negedge inside ACCESS, and MEM_RDATA is sampled at the posedge ending ACCESS. A read issued right after a write to the same address returns the new data.
- REQ dropped after grant: the latched command still completes, and ACK still pulses.
- RESET asserted during ACCESS or DONE aborts the transaction: no ACK is issued, and the outputs return to reset values immediately. If RESET lands before the access negedge, the memory is not written.
- Simultaneous requests in IDLE resolve in the same cycle, with no bubble.

## Test plan
- Reset: assert RESET mid-ACCESS of a CPU write to addr 3 → ACK never pulses, all outputs 0, state IDLE; memory word 3 unchanged provided RESET precedes the negedge.
- CPU write then read: write 0xDEADBEEF to addr 7 → CPU_ACK at +2 cycles, CPU_RDATA 0. Then read addr 7 → CPU_RDATA = 0xDEADBEEF, CPU_ERR 0, CPU_STALL high for exactly 2 cycles per transaction.
- Priority: CPU_REQ and DBG_REQ both held continuously → CPU granted 4 times, then DBG once, pattern repeating. DBG_ACK spacing is 15 cycles.
- Out-of-range: DBG read of addr 0x20 → MEM_ENABLE stays 0, DBG_ACK with DBG_ERR 1, DBG_RDATA 0.
- Back-to-back: CPU_REQ held high across ACK → second grant starts at the IDLE after DONE. MEM_WRITE pulses are never adjacent; at least 2 cycles separate them.
- DBG_REQ withdrawn in IDLE after 3 CPU grants → starve_cnt clears. When DBG_REQ returns with CPU_REQ high, DBG waits 4 CPU grants again.
